basic_computer_control_unit: RTL and testbench
==============================================

Name: basic_computer_control_unit

Overview:
- Hardwired timing-and-control unit for the 16-bit basic-computer datapath.
- Holds the 4-bit sequence counter (SC), the interrupt flip-flop R, the indirect flag I and the halt flag S.
- Decodes IR and drives every load/incr/clr, bus-select, ALU-select and memory-write line of the datapath.
- Sits beside the datapath. Datapath status outputs feed back in as inputs.

Parameters:
- SC_WIDTH, 4, sequence-counter width (timing states T0..T15).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IR_in  in  16  IR contents (bit15 = I, bits14:12 = opcode, bits11:0 = address/micro-op).
- AC_in  in  16  AC contents.
- DR_in  in  16  DR contents.
- E_in  in  1  E flip-flop.
- IEN_in  in  1  interrupt enable.
- fgi  in  1  input flag.
- fgo  in  1  output flag.
- AR_ld, PC_ld, DR_ld, AC_ld, IR_ld, TR_ld  out  1 each  register loads.
- AR_incr, PC_incr, DR_incr, AC_incr, TR_incr  out  1 each  register increments.
- AR_clr, PC_clr, DR_clr, AC_clr, TR_clr  out  1 each  register clears.
- E_ld, E_clr, E_incr  out  1 each  E control (E_incr toggles E).
- IEN_ld, IEN_clr  out  1 each  IEN set/clear.
- memory_write  out  1  write bus to M[AR].
- bus_select  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEMORY.
- alu_op_select  out  3  0 AND, 1 ADD, 2 DR, 3 CMA, 4 SHR-through-E, 5 SHL-through-E, 6/7 pass AC.
- sc_out  out  SC_WIDTH  current timing state.
- int_cycle  out  1  R flag.
- halted  out  1  S flag.

Behaviour:
- Reset while reset_n low:
  - SC=0, R=0, I=0, halted=0.
  - All controls 0 except AR_clr, PC_clr, DR_clr, AC_clr, TR_clr, E_clr, IEN_clr = 1 (combinational), so the datapath clears on the edge.
  - Reset mid-instruction aborts the instruction. First post-reset cycle is T0 fetch.
- Control outputs are combinational from (SC, R, I, IR_in, status). State updates on the rising clock edge. Memory read is combinational on the bus in the same cycle as AR.
- SC increments each cycle. "SC<-0" means next state is T0. While halted=1, SC holds and all controls are 0.
- Interrupt request: at any cycle with SC not in {T0, T1, T2}, R<-1 if IEN_in & (fgi|fgo) & ~R.
- Fetch/decode (R=0):
  - T0: AR<-PC.
  - T1: IR<-M[AR], PC++.
  - T2: AR<-IR[11:0], I<-IR_in[15].
- Interrupt cycle (R=1, replaces fetch):
  - T0: AR_clr, TR<-PC.
  - T1: M[AR]<-TR, PC_clr.
  - T2: PC++, IEN_clr, R<-0, SC<-0.
- T3, D7 = (opcode==7):
  - I=0: register-reference.
  - I=1: I/O.
  - Either way, execute the listed micro-ops, then SC<-0.
- T3, opcode != 7:
  - I=1: AR<-M[AR].
  - I=0: no operation.
- Memory-reference instructions, starting at T4:
  - AND / ADD / LDA:
    - T4: DR<-M[AR].
    - T5: AC_ld with ALU 0/1/2, SC<-0.
    - ADD additionally asserts E_ld (carry).
  - STA: T4: M[AR]<-AC, SC<-0.
  - BUN: T4: PC<-AR, SC<-0.
  - BSA:
    - T4: M[AR]<-PC, AR++.
    - T5: PC<-AR, SC<-0.
  - ISZ:
    - T4: DR<-M[AR].
    - T5: DR++.
    - T6: M[AR]<-DR; PC++ if DR_in==0; SC<-0.
- Register-reference (IR bits 11..0):
  - CLA: AC_clr.
  - CLE: E_clr.
  - CMA: AC_ld, ALU 3.
  - CME: E_incr.
  - CIR: AC_ld + E_ld, ALU 4.
  - CIL: AC_ld + E_ld, ALU 5.
  - INC: AC_incr.
  - SPA: skip if AC[15]=0.
  - SNA: skip if AC[15]=1.
  - SZA: skip if AC==0.
  - SZE: skip if E=0.
  - HLT: halted<-1.
  - Several AC-modifying bits set at once: only the highest-priority one acts, in order CLA>CMA>CIR>CIL>INC. Others (CLE/CME, skips, HLT) act concurrently.
  - All true skip conditions OR into a single PC_incr.
- I/O (IR bits 11..6):
  - SKI: skip if fgi.
  - SKO: skip if fgo.
  - ION: IEN_ld.
  - IOF: IEN_clr.
  - INP/OUT: no operation.
- Bus conflicts are impossible by construction: at most one bus source per cycle.
- An interrupt request arising during HLT's T3 is ignored.

Test Plan:
- ADD direct (0x1010 at PC=0, M[0x010]=0x0005, AC=0x0003) -> T0..T5, AC=0x0008, E=0, PC=1, SC back to 0 after 6 cycles.
- LDA indirect (0xA020, M[0x020]=0x0030, M[0x030]=0xBEEF) -> T3 loads AR=0x030, AC=0xBEEF at end of T5.
- ISZ (0x6040, M[0x040]=0xFFFF) -> M[0x040]=0x0000 written at T6, PC advances by 2 in total.
- ION then fgi=1 during execute -> R=1 set; next cycle set M[0]=return PC, PC=1, IEN=0, R=0.
- CIL with AC=0x8001, E=0 -> AC=0x0002, E=1. HLT (0x7001) -> halted=1, SC frozen, all controls 0 for 10 cycles.
- reset_n pulled low at T5 of ADD -> all clr lines high, SC=0, halted=0; after release, fetch restarts from PC=0, AC=0.

Source files
------------

// File: rtl/basic_computer_control_unit.sv
// ---------------------------------------------------------------------------
// basic_computer_control_unit
//
// Hardwired timing-and-control unit for the 16-bit basic-computer datapath.
// It holds the sequence counter (SC), the interrupt flip-flop R, the
// indirect flag I and the halt flag S. It decodes IR and drives every
// load/incr/clr, bus-select, ALU-select and memory-write line of the
// datapath. Datapath status comes back in as inputs.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   IR_in, AC_in, DR_in     datapath register contents
//   E_in, IEN_in            E flip-flop and interrupt-enable status
//   fgi, fgo                input / output device flags
//   *_ld, *_incr, *_clr     register load / increment / clear strobes
//   E_ld, E_clr, E_incr     E control (E_incr toggles E)
//   IEN_ld, IEN_clr         interrupt-enable set / clear
//   memory_write            write the bus into M[AR]
//   bus_select              0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM
//   alu_op_select           0 AND, 1 ADD, 2 DR, 3 CMA, 4 SHR, 5 SHL, 6/7 AC
//   sc_out                  current timing state
//   int_cycle               R flag
//   halted                  S flag
// ---------------------------------------------------------------------------
module basic_computer_control_unit #(
    parameter int SC_WIDTH = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [15:0]         IR_in,
    input  logic [15:0]         AC_in,
    input  logic [15:0]         DR_in,
    input  logic                E_in,
    input  logic                IEN_in,
    input  logic                fgi,
    input  logic                fgo,
    output logic                AR_ld,
    output logic                PC_ld,
    output logic                DR_ld,
    output logic                AC_ld,
    output logic                IR_ld,
    output logic                TR_ld,
    output logic                AR_incr,
    output logic                PC_incr,
    output logic                DR_incr,
    output logic                AC_incr,
    output logic                TR_incr,
    output logic                AR_clr,
    output logic                PC_clr,
    output logic                DR_clr,
    output logic                AC_clr,
    output logic                TR_clr,
    output logic                E_ld,
    output logic                E_clr,
    output logic                E_incr,
    output logic                IEN_ld,
    output logic                IEN_clr,
    output logic                memory_write,
    output logic [2:0]          bus_select,
    output logic [2:0]          alu_op_select,
    output logic [SC_WIDTH-1:0] sc_out,
    output logic                int_cycle,
    output logic                halted
);

    // Bus source codes
    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // ALU operation codes
    localparam logic [2:0] ALU_AND  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_DR   = 3'd2;
    localparam logic [2:0] ALU_CMA  = 3'd3;
    localparam logic [2:0] ALU_SHR  = 3'd4;
    localparam logic [2:0] ALU_SHL  = 3'd5;

    // Timing states
    localparam logic [SC_WIDTH-1:0] T0 = SC_WIDTH'(0);
    localparam logic [SC_WIDTH-1:0] T1 = SC_WIDTH'(1);
    localparam logic [SC_WIDTH-1:0] T2 = SC_WIDTH'(2);
    localparam logic [SC_WIDTH-1:0] T3 = SC_WIDTH'(3);
    localparam logic [SC_WIDTH-1:0] T4 = SC_WIDTH'(4);
    localparam logic [SC_WIDTH-1:0] T5 = SC_WIDTH'(5);
    localparam logic [SC_WIDTH-1:0] T6 = SC_WIDTH'(6);

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_ADD    = 3'd1,
        OP_LDA    = 3'd2,
        OP_STA    = 3'd3,
        OP_BUN    = 3'd4,
        OP_BSA    = 3'd5,
        OP_ISZ    = 3'd6,
        OP_REG_IO = 3'd7
    } opcode_t;

    logic [SC_WIDTH-1:0] sc;
    logic                r_flag;
    logic                i_flag;
    logic                s_flag;

    logic                sc_clr;
    logic                halt_set;
    logic                r_clr;
    logic                irq_req;
    opcode_t             opcode;
    logic [11:0]         ir_bits;
    logic                ac_zero;

    assign opcode  = opcode_t'(IR_in[14:12]);
    assign ir_bits = IR_in[11:0];
    assign ac_zero = (AC_in == 16'h0000);

    // An interrupt is only recognised outside the fetch/interrupt window
    // (T0..T2), and a halt being executed this cycle wins over it.
    assign irq_req = !s_flag && (sc >= T3) && IEN_in && (fgi || fgo)
                     && !r_flag && !halt_set;

    // Control decode. Everything here is combinational from SC, R, I, IR and
    // the datapath status. Holding reset low forces every clear line so the
    // datapath wipes itself on the clock edges seen during reset; while
    // halted, every control is idle.
    always_comb begin
        AR_ld         = 1'b0;
        PC_ld         = 1'b0;
        DR_ld         = 1'b0;
        AC_ld         = 1'b0;
        IR_ld         = 1'b0;
        TR_ld         = 1'b0;
        AR_incr       = 1'b0;
        PC_incr       = 1'b0;
        DR_incr       = 1'b0;
        AC_incr       = 1'b0;
        TR_incr       = 1'b0;
        AR_clr        = 1'b0;
        PC_clr        = 1'b0;
        DR_clr        = 1'b0;
        AC_clr        = 1'b0;
        TR_clr        = 1'b0;
        E_ld          = 1'b0;
        E_clr         = 1'b0;
        E_incr        = 1'b0;
        IEN_ld        = 1'b0;
        IEN_clr       = 1'b0;
        memory_write  = 1'b0;
        bus_select    = BUS_NONE;
        alu_op_select = ALU_AND;
        sc_clr        = 1'b0;
        halt_set      = 1'b0;
        r_clr         = 1'b0;

        if (!reset_n) begin
            AR_clr  = 1'b1;
            PC_clr  = 1'b1;
            DR_clr  = 1'b1;
            AC_clr  = 1'b1;
            TR_clr  = 1'b1;
            E_clr   = 1'b1;
            IEN_clr = 1'b1;
        end else if (!s_flag) begin
            if (sc == T0) begin
                if (r_flag) begin
                    // Interrupt: AR <- 0, TR <- PC (return address)
                    AR_clr     = 1'b1;
                    bus_select = BUS_PC;
                    TR_ld      = 1'b1;
                end else begin
                    bus_select = BUS_PC;
                    AR_ld      = 1'b1;
                end
            end else if (sc == T1) begin
                if (r_flag) begin
                    // Interrupt: M[0] <- TR, PC <- 0
                    bus_select   = BUS_TR;
                    memory_write = 1'b1;
                    PC_clr       = 1'b1;
                end else begin
                    bus_select = BUS_MEM;
                    IR_ld      = 1'b1;
                    PC_incr    = 1'b1;
                end
            end else if (sc == T2) begin
                if (r_flag) begin
                    // Interrupt: PC <- 1, disable interrupts, back to fetch
                    PC_incr = 1'b1;
                    IEN_clr = 1'b1;
                    r_clr   = 1'b1;
                    sc_clr  = 1'b1;
                end else begin
                    bus_select = BUS_IR;
                    AR_ld      = 1'b1;
                end
            end else if (sc == T3) begin
                if (opcode == OP_REG_IO) begin
                    sc_clr = 1'b1;
                    if (!i_flag) begin
                        // Only one AC-modifying micro-op acts, highest priority first
                        if (ir_bits[11]) begin
                            AC_clr = 1'b1;
                        end else if (ir_bits[9]) begin
                            AC_ld         = 1'b1;
                            alu_op_select = ALU_CMA;
                        end else if (ir_bits[7]) begin
                            AC_ld         = 1'b1;
                            E_ld          = 1'b1;
                            alu_op_select = ALU_SHR;
                        end else if (ir_bits[6]) begin
                            AC_ld         = 1'b1;
                            E_ld          = 1'b1;
                            alu_op_select = ALU_SHL;
                        end else if (ir_bits[5]) begin
                            AC_incr = 1'b1;
                        end
                        E_clr    = ir_bits[10];
                        E_incr   = ir_bits[8];
                        // All true skip conditions merge into one PC increment
                        PC_incr  = (ir_bits[4] && !AC_in[15]) ||
                                   (ir_bits[3] &&  AC_in[15]) ||
                                   (ir_bits[2] &&  ac_zero)   ||
                                   (ir_bits[1] && !E_in);
                        halt_set = ir_bits[0];
                    end else begin
                        // I/O: INP/OUT have no device behind them here
                        PC_incr = (ir_bits[9] && fgi) || (ir_bits[8] && fgo);
                        IEN_ld  = ir_bits[7];
                        IEN_clr = ir_bits[6];
                    end
                end else if (i_flag) begin
                    // Indirect: AR <- M[AR]
                    bus_select = BUS_MEM;
                    AR_ld      = 1'b1;
                end
            end else begin
                // Memory-reference execution, T4 onward
                case (opcode)
                    OP_AND, OP_ADD, OP_LDA: begin
                        if (sc == T4) begin
                            bus_select = BUS_MEM;
                            DR_ld      = 1'b1;
                        end else if (sc == T5) begin
                            AC_ld  = 1'b1;
                            sc_clr = 1'b1;
                            if (opcode == OP_ADD) begin
                                alu_op_select = ALU_ADD;
                                E_ld          = 1'b1;
                            end else if (opcode == OP_LDA) begin
                                alu_op_select = ALU_DR;
                            end else begin
                                alu_op_select = ALU_AND;
                            end
                        end
                    end
                    OP_STA: begin
                        if (sc == T4) begin
                            bus_select   = BUS_AC;
                            memory_write = 1'b1;
                            sc_clr       = 1'b1;
                        end
                    end
                    OP_BUN: begin
                        if (sc == T4) begin
                            bus_select = BUS_AR;
                            PC_ld      = 1'b1;
                            sc_clr     = 1'b1;
                        end
                    end
                    OP_BSA: begin
                        if (sc == T4) begin
                            bus_select   = BUS_PC;
                            memory_write = 1'b1;
                            AR_incr      = 1'b1;
                        end else if (sc == T5) begin
                            bus_select = BUS_AR;
                            PC_ld      = 1'b1;
                            sc_clr     = 1'b1;
                        end
                    end
                    OP_ISZ: begin
                        if (sc == T4) begin
                            bus_select = BUS_MEM;
                            DR_ld      = 1'b1;
                        end else if (sc == T5) begin
                            DR_incr = 1'b1;
                        end else if (sc == T6) begin
                            bus_select   = BUS_DR;
                            memory_write = 1'b1;
                            PC_incr      = (DR_in == 16'h0000);
                            sc_clr       = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Sequencing state. SC advances every cycle unless the current step ends
    // the instruction; the halt flag freezes all state until the next reset.
    // I is captured from IR only during a real fetch, never during the
    // interrupt cycle that replaces it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sc     <= '0;
            r_flag <= 1'b0;
            i_flag <= 1'b0;
            s_flag <= 1'b0;
        end else if (!s_flag) begin
            sc <= sc_clr ? '0 : sc + SC_WIDTH'(1);
            if ((sc == T2) && !r_flag) begin
                i_flag <= IR_in[15];
            end
            if (r_clr) begin
                r_flag <= 1'b0;
            end else if (irq_req) begin
                r_flag <= 1'b1;
            end
            if (halt_set) begin
                s_flag <= 1'b1;
            end
        end
    end

    assign sc_out    = sc;
    assign int_cycle = r_flag;
    assign halted    = s_flag;

endmodule

// File: tb/tb_basic_computer_control_unit.sv
// ---------------------------------------------------------------------------
// tb_basic_computer_control_unit
//
// Wraps the control unit in a small behavioural model of the basic-computer
// datapath (registers, bus, ALU, 4K memory) and runs short programs through
// it. Expected architectural results are queued per program and compared at
// the cycle they are due.
// ---------------------------------------------------------------------------
module tb_basic_computer_control_unit;

    localparam int K_SC   = 0;
    localparam int K_AC   = 1;
    localparam int K_E    = 2;
    localparam int K_PC   = 3;
    localparam int K_AR   = 4;
    localparam int K_MEM  = 5;
    localparam int K_INT  = 6;
    localparam int K_HALT = 7;
    localparam int K_IEN  = 8;
    localparam int K_CTRL = 9;
    localparam int K_BUS  = 10;

    localparam int P_MEM    = 0;
    localparam int P_AC     = 1;
    localparam int P_E      = 2;
    localparam int P_PC     = 3;
    localparam int P_CLRMEM = 4;

    typedef struct {
        int          cyc;
        int          kind;
        int          addr;
        logic [31:0] value;
        string       tag;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fgi;
    logic        fgo;

    logic        AR_ld, PC_ld, DR_ld, AC_ld, IR_ld, TR_ld;
    logic        AR_incr, PC_incr, DR_incr, AC_incr, TR_incr;
    logic        AR_clr, PC_clr, DR_clr, AC_clr, TR_clr;
    logic        E_ld, E_clr, E_incr, IEN_ld, IEN_clr, memory_write;
    logic [2:0]  bus_select;
    logic [2:0]  alu_op_select;
    logic [3:0]  sc_out;
    logic        int_cycle;
    logic        halted;

    logic [11:0] ar, pc;
    logic [15:0] dr, ac, ir, tr;
    logic        e, ien;
    logic [15:0] mem [0:4095];
    logic [15:0] bus;
    logic [15:0] alu_ac;
    logic        alu_e;

    logic        poke_en;
    int          poke_kind;
    logic [11:0] poke_addr;
    logic [15:0] poke_data;

    logic        non_clr_any;
    logic        ctrl_any;
    logic [6:0]  clr_vec;

    int          checks;
    int          errors;
    exp_t        sb [$];
    int          run_len [8] = '{6, 6, 7, 7, 11, 18, 12, 24};

    always #5 clock = ~clock;

    basic_computer_control_unit #(.SC_WIDTH(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .IR_in         (ir),
        .AC_in         (ac),
        .DR_in         (dr),
        .E_in          (e),
        .IEN_in        (ien),
        .fgi           (fgi),
        .fgo           (fgo),
        .AR_ld         (AR_ld),
        .PC_ld         (PC_ld),
        .DR_ld         (DR_ld),
        .AC_ld         (AC_ld),
        .IR_ld         (IR_ld),
        .TR_ld         (TR_ld),
        .AR_incr       (AR_incr),
        .PC_incr       (PC_incr),
        .DR_incr       (DR_incr),
        .AC_incr       (AC_incr),
        .TR_incr       (TR_incr),
        .AR_clr        (AR_clr),
        .PC_clr        (PC_clr),
        .DR_clr        (DR_clr),
        .AC_clr        (AC_clr),
        .TR_clr        (TR_clr),
        .E_ld          (E_ld),
        .E_clr         (E_clr),
        .E_incr        (E_incr),
        .IEN_ld        (IEN_ld),
        .IEN_clr       (IEN_clr),
        .memory_write  (memory_write),
        .bus_select    (bus_select),
        .alu_op_select (alu_op_select),
        .sc_out        (sc_out),
        .int_cycle     (int_cycle),
        .halted        (halted)
    );

    assign clr_vec     = {AR_clr, PC_clr, DR_clr, AC_clr, TR_clr, E_clr, IEN_clr};
    assign non_clr_any = AR_ld | PC_ld | DR_ld | AC_ld | IR_ld | TR_ld |
                         AR_incr | PC_incr | DR_incr | AC_incr | TR_incr |
                         E_ld | E_incr | IEN_ld | memory_write |
                         (bus_select != 3'd0) | (alu_op_select != 3'd0);
    assign ctrl_any    = non_clr_any | (|clr_vec);

    // Datapath bus: memory read is combinational from AR
    always_comb begin
        case (bus_select)
            3'd1:    bus = {4'h0, ar};
            3'd2:    bus = {4'h0, pc};
            3'd3:    bus = dr;
            3'd4:    bus = ac;
            3'd5:    bus = ir;
            3'd6:    bus = tr;
            3'd7:    bus = mem[ar];
            default: bus = 16'h0000;
        endcase
    end

    // ALU with E as carry / shift bit
    always_comb begin
        alu_ac = ac;
        alu_e  = e;
        case (alu_op_select)
            3'd0: alu_ac = ac & dr;
            3'd1: {alu_e, alu_ac} = {1'b0, ac} + {1'b0, dr};
            3'd2: alu_ac = dr;
            3'd3: alu_ac = ~ac;
            3'd4: begin alu_ac = {e, ac[15:1]}; alu_e = ac[0]; end
            3'd5: begin alu_ac = {ac[14:0], e}; alu_e = ac[15]; end
            default: alu_ac = ac;
        endcase
    end

    // Register file and memory; pokes preload state while reset is held
    always @(posedge clock) begin
        if (poke_en) begin
            case (poke_kind)
                P_MEM:    mem[poke_addr] <= poke_data;
                P_AC:     ac <= poke_data;
                P_E:      e  <= poke_data[0];
                P_PC:     pc <= poke_data[11:0];
                P_CLRMEM: for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
                default:  ;
            endcase
        end else begin
            if (AR_clr) ar <= 12'h000; else if (AR_ld) ar <= bus[11:0]; else if (AR_incr) ar <= ar + 12'h001;
            if (PC_clr) pc <= 12'h000; else if (PC_ld) pc <= bus[11:0]; else if (PC_incr) pc <= pc + 12'h001;
            if (DR_clr) dr <= 16'h0000; else if (DR_ld) dr <= bus; else if (DR_incr) dr <= dr + 16'h0001;
            if (AC_clr) ac <= 16'h0000; else if (AC_ld) ac <= alu_ac; else if (AC_incr) ac <= ac + 16'h0001;
            if (TR_clr) tr <= 16'h0000; else if (TR_ld) tr <= bus; else if (TR_incr) tr <= tr + 16'h0001;
            if (IR_ld) ir <= bus;
            if (E_clr) e <= 1'b0; else if (E_ld) e <= alu_e; else if (E_incr) e <= ~e;
            if (IEN_clr) ien <= 1'b0; else if (IEN_ld) ien <= 1'b1;
            if (memory_write) mem[ar] <= bus;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] observe(input int kind, input int addr);
        logic [11:0] a;
        a = addr[11:0];
        case (kind)
            K_SC:    return 32'(sc_out);
            K_AC:    return 32'(ac);
            K_E:     return 32'(e);
            K_PC:    return 32'(pc);
            K_AR:    return 32'(ar);
            K_MEM:   return 32'(mem[a]);
            K_INT:   return 32'(int_cycle);
            K_HALT:  return 32'(halted);
            K_IEN:   return 32'(ien);
            K_CTRL:  return 32'(ctrl_any);
            K_BUS:   return 32'(bus_select);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic push(input int cyc, input int kind, input int addr,
                        input logic [31:0] value, input string tag);
        exp_t x;
        x.cyc = cyc; x.kind = kind; x.addr = addr; x.value = value; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic drain(input int cyc);
        exp_t x;
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                x = sb[i];
                sb.delete(i);
                checkOutput(x.tag, observe(x.kind, x.addr), x.value);
            end else begin
                i++;
            end
        end
    endtask

    // Runs n clock cycles after reset release, comparing due expectations
    // one time unit after each rising edge.
    task automatic run_cycles(input int n);
        #1;
        drain(0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clock);
            #1;
            drain(c);
        end
        checkOutput("sb_all_reached", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic poke(input int kind, input int addr, input logic [15:0] data);
        poke_en   = 1'b1;
        poke_kind = kind;
        poke_addr = addr[11:0];
        poke_data = data;
        @(negedge clock);
        poke_en   = 1'b0;
    endtask

    // Resets the machine, loads a program and queues its expected results.
    // Ends at a falling edge with reset released.
    task automatic applyStimulus(input int scen);
        @(negedge clock);
        reset_n = 1'b0;
        fgi     = 1'b0;
        fgo     = 1'b0;
        @(negedge clock);
        poke(P_CLRMEM, 0, 16'h0000);
        case (scen)
            0, 8: begin
                poke(P_MEM, 12'h000, 16'h1010);
                poke(P_MEM, 12'h010, 16'h0005);
                poke(P_AC,  0,       16'h0003);
                if (scen == 0) begin
                    push(0, K_BUS, 0, 2, "add_t0_bus_pc");
                    for (int c = 1; c <= 5; c++) push(c, K_SC, 0, c, "add_sc");
                    push(3, K_AR, 0, 32'h010, "add_ar");
                    push(6, K_SC, 0, 0,        "add_sc_wrap");
                    push(6, K_AC, 0, 32'h0008, "add_ac");
                    push(6, K_E,  0, 0,        "add_e");
                    push(6, K_PC, 0, 1,        "add_pc");
                end else begin
                    push(5, K_SC, 0, 5, "rst_pre_sc");
                end
            end
            1: begin
                poke(P_MEM, 12'h000, 16'hA020);
                poke(P_MEM, 12'h020, 16'h0030);
                poke(P_MEM, 12'h030, 16'hBEEF);
                push(3, K_AR, 0, 32'h020,  "lda_ar_direct");
                push(4, K_AR, 0, 32'h030,  "lda_ar_indirect");
                push(6, K_AC, 0, 32'hBEEF, "lda_ac");
                push(6, K_PC, 0, 1,        "lda_pc");
                push(6, K_SC, 0, 0,        "lda_sc");
            end
            2: begin
                poke(P_MEM, 12'h000, 16'h6040);
                poke(P_MEM, 12'h040, 16'hFFFF);
                push(6, K_SC,  0,      6,        "isz_sc_t6");
                push(6, K_MEM, 12'h040, 32'hFFFF, "isz_mem_before");
                push(7, K_MEM, 12'h040, 32'h0000, "isz_mem_wrap");
                push(7, K_PC,  0,      2,        "isz_pc_skip");
                push(7, K_SC,  0,      0,        "isz_sc");
            end
            3: begin
                poke(P_MEM, 12'h000, 16'h6040);
                poke(P_MEM, 12'h040, 16'h0005);
                push(7, K_MEM, 12'h040, 32'h0006, "isz_mem_inc");
                push(7, K_PC,  0,      1,        "isz_pc_noskip");
            end
            4: begin
                poke(P_MEM, 12'h000, 16'hF080);
                poke(P_MEM, 12'h001, 16'h7020);
                fgi = 1'b1;
                push(4,  K_IEN, 0, 1, "int_ien_on");
                push(4,  K_INT, 0, 0, "int_r_ion");
                push(7,  K_INT, 0, 0, "int_r_fetch");
                push(8,  K_INT, 0, 1, "int_r_set");
                push(8,  K_AC,  0, 1, "int_inc_ac");
                push(8,  K_SC,  0, 0, "int_sc");
                push(9,  K_AR,  0, 0, "int_ar_clr");
                push(10, K_MEM, 0, 2, "int_ret_addr");
                push(10, K_PC,  0, 0, "int_pc_clr");
                push(11, K_PC,  0, 1, "int_pc");
                push(11, K_IEN, 0, 0, "int_ien_off");
                push(11, K_INT, 0, 0, "int_r_clr");
                push(11, K_SC,  0, 0, "int_sc_end");
            end
            5: begin
                poke(P_MEM, 12'h000, 16'h7040);
                poke(P_MEM, 12'h001, 16'h7001);
                poke(P_AC,  0,       16'h8001);
                push(4, K_AC,   0, 32'h0002, "cil_ac");
                push(4, K_E,    0, 1,        "cil_e");
                push(4, K_PC,   0, 1,        "cil_pc");
                push(7, K_HALT, 0, 0,        "hlt_not_yet");
                for (int c = 8; c <= 18; c++) begin
                    push(c, K_CTRL, 0, 0, "hlt_ctrl_idle");
                    push(c, K_SC,   0, 0, "hlt_sc_frozen");
                end
                push(8,  K_HALT, 0, 1, "hlt_set");
                push(18, K_HALT, 0, 1, "hlt_held");
                push(18, K_PC,   0, 2, "hlt_pc");
            end
            6: begin
                poke(P_MEM, 12'h000, 16'h7A04);
                poke(P_MEM, 12'h001, 16'h7004);
                poke(P_MEM, 12'h003, 16'h7100);
                poke(P_AC,  0,       16'h1234);
                push(4,  K_AC, 0, 32'h0000, "prio_cla_wins");
                push(4,  K_PC, 0, 1,        "sza_false");
                push(8,  K_PC, 0, 3,        "sza_true");
                push(12, K_E,  0, 1,        "cme_e");
                push(12, K_PC, 0, 4,        "cme_pc");
            end
            7: begin
                poke(P_MEM, 12'h000, 16'h3050);
                poke(P_MEM, 12'h001, 16'h5060);
                poke(P_MEM, 12'h061, 16'h4070);
                poke(P_MEM, 12'h070, 16'hF200);
                poke(P_MEM, 12'h071, 16'hF100);
                poke(P_AC,  0,       16'h1357);
                fgo = 1'b1;
                push(5,  K_MEM, 12'h050, 32'h1357, "sta_mem");
                push(5,  K_PC,  0,       1,        "sta_pc");
                push(11, K_MEM, 12'h060, 32'h0002, "bsa_mem");
                push(11, K_PC,  0,       32'h061,  "bsa_pc");
                push(16, K_PC,  0,       32'h070,  "bun_pc");
                push(20, K_PC,  0,       32'h071,  "ski_noskip");
                push(24, K_PC,  0,       32'h073,  "sko_skip");
                push(24, K_AC,  0,       32'h1357, "io_ac_kept");
            end
            default: ;
        endcase
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        fgi       = 1'b0;
        fgo       = 1'b0;
        poke_en   = 1'b0;
        poke_kind = 0;
        poke_addr = 12'h000;
        poke_data = 16'h0000;

        for (int s = 0; s < 8; s++) begin
            applyStimulus(s);
            run_cycles(run_len[s]);
        end

        // Reset in the middle of ADD (at T5) aborts it and clears the datapath
        applyStimulus(8);
        run_cycles(5);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_clr_lines", 32'(clr_vec), 32'h7F);
        checkOutput("rst_other_ctrl", 32'(non_clr_any), 32'd0);
        checkOutput("rst_sc", 32'(sc_out), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_int", 32'(int_cycle), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("rst_ac_cleared", 32'(ac), 32'd0);
        checkOutput("rst_pc_cleared", 32'(pc), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        push(0, K_SC, 0, 0,        "rst_restart_t0");
        push(3, K_SC, 0, 3,        "rst_restart_sc");
        push(6, K_AC, 0, 32'h0005, "rst_restart_ac");
        push(6, K_PC, 0, 1,        "rst_restart_pc");
        push(6, K_SC, 0, 0,        "rst_restart_wrap");
        run_cycles(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
